// File: rtl/fb_write_sched_pkg.sv
// Shared definitions for the framebuffer write scheduler: state encoding,
// default sweep limits matching the 160x120 VGA framebuffer, and the arbiter pick.
package fb_write_sched_pkg;

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } sched_state_t;

  localparam int DEF_XMAX = 159;
  localparam int DEF_YMAX = 119;

  // Colours are packed {R,G,B}, R in the most significant CW bits.
  localparam int RGB_CHANNELS = 3;

  // Round-robin pick between two requesters; returns {found, grant_index}.
  function automatic logic [1:0] rr_pick(input logic v0, input logic v1,
                                         input logic last_grant);
    logic [1:0] res;
    if (v0 && v1) begin
      res = {1'b1, ~last_grant};
    end else if (v0) begin
      res = 2'b10;
    end else if (v1) begin
      res = 2'b11;
    end else begin
      res = 2'b00;
    end
    return res;
  endfunction

endpackage

// File: rtl/fb_write_sched_if.sv
// Requester and framebuffer write-port bundle for fb_write_sched.
// master = requesters / write-port owner, slave = the scheduler.
interface fb_write_sched_if #(
  parameter int XW = 8,
  parameter int YW = 8,
  parameter int CW = 3
) ();

  logic          req0_valid;
  logic [XW-1:0] req0_x;
  logic [YW-1:0] req0_y;
  logic [3*CW-1:0] req0_rgb;
  logic          req0_ready;

  logic          req1_valid;
  logic [XW-1:0] req1_x;
  logic [YW-1:0] req1_y;
  logic [3*CW-1:0] req1_rgb;
  logic          req1_ready;

  logic          wr_en;
  logic          wr_ready;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic [CW-1:0] wr_r;
  logic [CW-1:0] wr_g;
  logic [CW-1:0] wr_b;

  modport master (
    output req0_valid, req0_x, req0_y, req0_rgb,
    input  req0_ready,
    output req1_valid, req1_x, req1_y, req1_rgb,
    input  req1_ready,
    input  wr_en, wr_x, wr_y, wr_r, wr_g, wr_b,
    output wr_ready
  );

  modport slave (
    input  req0_valid, req0_x, req0_y, req0_rgb,
    output req0_ready,
    input  req1_valid, req1_x, req1_y, req1_rgb,
    output req1_ready,
    output wr_en, wr_x, wr_y, wr_r, wr_g, wr_b,
    input  wr_ready
  );

endinterface

// File: rtl/fb_clear_sweep.sv
// Row-major (cx,cy) sweep counter for clear-screen; advances once per issued pixel.
// last flags the final pixel (XMAX,YMAX); done is last qualified by advance.
module fb_clear_sweep #(
  parameter int XW   = 8,
  parameter int YW   = 8,
  parameter int XMAX = 159,
  parameter int YMAX = 119
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          restart,
  input  logic          advance,
  output logic [XW-1:0] cx,
  output logic [YW-1:0] cy,
  output logic          last,
  output logic          done
);

  localparam logic [XW-1:0] X_LAST = XW'(XMAX);
  localparam logic [YW-1:0] Y_LAST = YW'(YMAX);

  logic [XW-1:0] r_cx;
  logic [YW-1:0] r_cy;

  // Sweep position: restart rewinds to origin, advance steps row-major.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cx <= {XW{1'b0}};
      r_cy <= {YW{1'b0}};
    end else if (restart) begin
      r_cx <= {XW{1'b0}};
      r_cy <= {YW{1'b0}};
    end else if (advance) begin
      if (r_cx == X_LAST) begin
        r_cx <= {XW{1'b0}};
        if (r_cy == Y_LAST) begin
          r_cy <= {YW{1'b0}};
        end else begin
          r_cy <= r_cy + YW'(1);
        end
      end else begin
        r_cx <= r_cx + XW'(1);
      end
    end
  end

  assign cx   = r_cx;
  assign cy   = r_cy;
  assign last = (r_cx == X_LAST) && (r_cy == Y_LAST);
  assign done = advance && last;

endmodule

// File: rtl/fb_write_sched.sv
// Shares the VGA framebuffer write port between the draw engine (req0) and manual
// putpixel (req1), with a clear-screen sweep that pre-empts both.
module fb_write_sched
  import fb_write_sched_pkg::*;
#(
  parameter int XW   = 8,
  parameter int YW   = 8,
  parameter int CW   = 3,
  parameter int XMAX = DEF_XMAX,
  parameter int YMAX = DEF_YMAX
) (
  input  logic              CLK,
  input  logic              NRST,
  fb_write_sched_if.slave   bus,
  input  logic              clear_start,
  input  logic [3*CW-1:0]   clear_rgb,
  output logic              busy,
  output logic              clear_done
);

  sched_state_t    r_state;
  logic            r_last_grant;
  logic [3*CW-1:0] r_fill;
  logic            r_wr_en;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [3*CW-1:0] r_rgb;
  logic            r_busy;
  logic            r_done;

  logic            w_load;
  logic            w_arb;
  logic [1:0]      w_pick;
  logic            w_win_v;
  logic            w_win_g;
  logic [XW-1:0]   w_sel_x;
  logic [YW-1:0]   w_sel_y;
  logic [3*CW-1:0] w_sel_rgb;
  logic [XW-1:0]   w_cx;
  logic [YW-1:0]   w_cy;
  logic            w_sweep_last;
  logic            w_sweep_done;
  logic            w_clr_adv;
  logic            w_clr_restart;

  // The slot can take new data when empty or when its held write drains now.
  assign w_load  = !r_wr_en || bus.wr_ready;
  assign w_arb   = (r_state == ST_ARB);
  assign w_pick  = rr_pick(bus.req0_valid, bus.req1_valid, r_last_grant);
  assign w_win_v = w_pick[1];
  assign w_win_g = w_pick[0];

  assign bus.req0_ready = w_load && w_arb && w_win_v && !w_win_g;
  assign bus.req1_ready = w_load && w_arb && w_win_v &&  w_win_g;

  assign w_clr_adv     = w_load && (r_state == ST_CLEAR);
  assign w_clr_restart = w_arb && clear_start;

  // Winner data mux feeding the output slot.
  always_comb begin
    w_sel_x   = bus.req0_x;
    w_sel_y   = bus.req0_y;
    w_sel_rgb = bus.req0_rgb;
    if (w_win_g) begin
      w_sel_x   = bus.req1_x;
      w_sel_y   = bus.req1_y;
      w_sel_rgb = bus.req1_rgb;
    end else begin
      w_sel_x   = bus.req0_x;
      w_sel_y   = bus.req0_y;
      w_sel_rgb = bus.req0_rgb;
    end
  end

  fb_clear_sweep #(
    .XW   (XW),
    .YW   (YW),
    .XMAX (XMAX),
    .YMAX (YMAX)
  ) u_sweep (
    .clk     (CLK),
    .rst_n   (NRST),
    .restart (w_clr_restart),
    .advance (w_clr_adv),
    .cx      (w_cx),
    .cy      (w_cy),
    .last    (w_sweep_last),
    .done    (w_sweep_done)
  );

  // Scheduler FSM and registered output slot.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_state      <= ST_ARB;
      r_last_grant <= 1'b1;
      r_fill       <= {(3*CW){1'b0}};
      r_wr_en      <= 1'b0;
      r_x          <= {XW{1'b0}};
      r_y          <= {YW{1'b0}};
      r_rgb        <= {(3*CW){1'b0}};
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_sweep_done;
      case (r_state)
        ST_ARB: begin
          if (w_load) begin
            if (w_win_v) begin
              r_wr_en      <= 1'b1;
              r_x          <= w_sel_x;
              r_y          <= w_sel_y;
              r_rgb        <= w_sel_rgb;
              r_last_grant <= w_win_g;
            end else begin
              r_wr_en <= 1'b0;
            end
          end
          // A request granted alongside clear_start has already been taken above.
          if (clear_start) begin
            r_state <= ST_CLEAR;
            r_fill  <= clear_rgb;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (w_load) begin
            r_wr_en <= 1'b1;
            r_x     <= w_cx;
            r_y     <= w_cy;
            r_rgb   <= r_fill;
            if (w_sweep_last) begin
              r_state <= ST_ARB;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_ARB;
        end
      endcase
    end
  end

  assign bus.wr_en = r_wr_en;
  assign bus.wr_x  = r_x;
  assign bus.wr_y  = r_y;
  assign bus.wr_r  = r_rgb[3*CW-1:2*CW];
  assign bus.wr_g  = r_rgb[2*CW-1:CW];
  assign bus.wr_b  = r_rgb[CW-1:0];
  assign busy       = r_busy;
  assign clear_done = r_done;

endmodule

// File: tb/tb_fb_write_sched.sv
// Self-checking bench for fb_write_sched on a 4x2 clear frame: directed cases
// plus randomized traffic compared each cycle against a behavioural model.
module tb_fb_write_sched;

  localparam int XW = 8;
  localparam int YW = 8;
  localparam int CW = 3;
  localparam int XMAX = 3;
  localparam int YMAX = 1;
  localparam int W = XMAX + 1;
  localparam int TOTAL = (XMAX + 1) * (YMAX + 1);

  logic CLK;
  logic NRST;
  logic clear_start;
  logic [3*CW-1:0] clear_rgb;
  logic busy;
  logic clear_done;

  fb_write_sched_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();

  fb_write_sched #(.XW(XW), .YW(YW), .CW(CW), .XMAX(XMAX), .YMAX(YMAX)) dut (
    .CLK         (CLK),
    .NRST        (NRST),
    .bus         (bus),
    .clear_start (clear_start),
    .clear_rgb   (clear_rgb),
    .busy        (busy),
    .clear_done  (clear_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: one pending write, clear progress as a linear pixel index.
  logic         m_pend, m_busy, m_done, m_lastg;
  logic [XW-1:0] m_x;
  logic [YW-1:0] m_y;
  logic [3*CW-1:0] m_rgb, m_fill;
  int           m_n;
  logic         m_take, m_win, m_wg, m_r0, m_r1;
  logic [XW+YW+3*CW-1:0] log_q[$];

  task automatic model_reset();
    m_pend = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_lastg = 1'b1;
    m_x = '0; m_y = '0; m_rgb = '0; m_fill = '0; m_n = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge CLK);
      if (!NRST) model_reset();
      m_take = !m_pend || bus.wr_ready;
      m_win = 1'b0;
      m_wg = 1'b0;
      if (!m_busy && m_take) begin
        if (bus.req0_valid && bus.req1_valid) begin m_win = 1'b1; m_wg = !m_lastg; end
        else if (bus.req0_valid) begin m_win = 1'b1; m_wg = 1'b0; end
        else if (bus.req1_valid) begin m_win = 1'b1; m_wg = 1'b1; end
      end
      m_r0 = m_win && !m_wg;
      m_r1 = m_win && m_wg;
      chk("m_wr_en", bus.wr_en, m_pend);
      chk("m_wr_x", bus.wr_x, m_x);
      chk("m_wr_y", bus.wr_y, m_y);
      chk("m_wr_rgb", {bus.wr_r, bus.wr_g, bus.wr_b}, m_rgb);
      chk("m_busy", busy, m_busy);
      chk("m_clear_done", clear_done, m_done);
      chk("m_req0_ready", bus.req0_ready, m_r0);
      chk("m_req1_ready", bus.req1_ready, m_r1);
      if (NRST && bus.wr_en && bus.wr_ready)
        log_q.push_back({bus.wr_x, bus.wr_y, bus.wr_r, bus.wr_g, bus.wr_b});
      @(posedge CLK);
      if (!NRST) begin
        model_reset();
      end else begin
        m_done = 1'b0;
        if (!m_busy) begin
          if (m_take) begin
            if (m_win) begin
              m_pend = 1'b1;
              m_lastg = m_wg;
              m_x   = m_wg ? bus.req1_x   : bus.req0_x;
              m_y   = m_wg ? bus.req1_y   : bus.req0_y;
              m_rgb = m_wg ? bus.req1_rgb : bus.req0_rgb;
            end else begin
              m_pend = 1'b0;
            end
          end
          if (clear_start) begin
            m_busy = 1'b1; m_fill = clear_rgb; m_n = 0;
          end
        end else if (m_take) begin
          m_pend = 1'b1;
          m_x = XW'(m_n % W);
          m_y = YW'(m_n / W);
          m_rgb = m_fill;
          if (m_n == TOTAL - 1) begin m_done = 1'b1; m_busy = 1'b0; end
          else m_n++;
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_x = '0; bus.req0_y = '0; bus.req0_rgb = '0;
    bus.req1_x = '0; bus.req1_y = '0; bus.req1_rgb = '0;
    bus.wr_ready = 1'b1;
    clear_start = 1'b0;
    clear_rgb = '0;
  endtask

  // Asserts NRST between edges; optionally checks outputs cleared with no edge.
  task automatic do_reset(input bit chk_async);
    @(posedge CLK);
    #2;
    NRST = 1'b0;
    idle_inputs();
    #1;
    if (chk_async) begin
      chk("async_wr_en", bus.wr_en, 0);
      chk("async_wr_x", bus.wr_x, 0);
      chk("async_busy", busy, 0);
      chk("async_clear_done", clear_done, 0);
    end
    repeat (2) @(posedge CLK);
    #1;
    NRST = 1'b1;
  endtask

  initial begin
    int g;
    int done_cnt;
    int busy_cyc;
    bit got;
    logic [XW+YW+3*CW-1:0] e;

    NRST = 1'b0;
    idle_inputs();
    repeat (3) @(posedge CLK);
    #1;
    NRST = 1'b1;

    // Idle after reset.
    @(negedge CLK);
    chk("idle_wr_en", bus.wr_en, 0);
    chk("idle_req0_ready", bus.req0_ready, 0);
    chk("idle_req1_ready", bus.req1_ready, 0);
    chk("idle_busy", busy, 0);
    step();

    // Single req0 write, one-cycle latency.
    bus.req0_valid = 1'b1; bus.req0_x = 8'd10; bus.req0_y = 8'd20; bus.req0_rgb = 9'o751;
    @(negedge CLK);
    chk("single_req0_ready", bus.req0_ready, 1);
    step();
    bus.req0_valid = 1'b0;
    bus.wr_ready = 1'b0;
    @(negedge CLK);
    chk("single_wr_en", bus.wr_en, 1);
    chk("single_wr_x", bus.wr_x, 10);
    chk("single_wr_y", bus.wr_y, 20);
    chk("single_wr_r", bus.wr_r, 7);
    chk("single_wr_g", bus.wr_g, 5);
    chk("single_wr_b", bus.wr_b, 1);
    do_reset(1'b1);

    // Round robin with both requesters always valid.
    bus.req0_valid = 1'b1; bus.req0_x = 8'd1; bus.req0_y = 8'd1; bus.req0_rgb = 9'o111;
    bus.req1_valid = 1'b1; bus.req1_x = 8'd2; bus.req1_y = 8'd2; bus.req1_rgb = 9'o222;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      g = bus.req1_ready ? 1 : 0;
      chk("rr_any_ready", bus.req0_ready | bus.req1_ready, 1);
      chk("rr_grant", g, i % 2);
      if (i > 0) chk("rr_no_gap", bus.wr_en, 1);
      step();
    end
    do_reset(1'b0);

    // Back-pressure holds the slot and blocks new grants.
    bus.req0_valid = 1'b1; bus.req0_x = 8'd1; bus.req0_y = 8'd2; bus.req0_rgb = 9'o123;
    @(negedge CLK);
    chk("bp_first_ready", bus.req0_ready, 1);
    step();
    bus.wr_ready = 1'b0;
    bus.req0_x = 8'd3; bus.req0_y = 8'd4; bus.req0_rgb = 9'o456;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bp_hold_en", bus.wr_en, 1);
      chk("bp_hold_x", bus.wr_x, 1);
      chk("bp_hold_y", bus.wr_y, 2);
      chk("bp_hold_rgb", {bus.wr_r, bus.wr_g, bus.wr_b}, 9'o123);
      chk("bp_req0_blocked", bus.req0_ready, 0);
      step();
    end
    bus.wr_ready = 1'b1;
    @(negedge CLK);
    chk("bp_release_ready", bus.req0_ready, 1);
    step();
    bus.req0_valid = 1'b0;
    @(negedge CLK);
    chk("bp_next_x", bus.wr_x, 3);
    chk("bp_next_y", bus.wr_y, 4);
    do_reset(1'b0);

    // Clear sweep with a mid-sweep restart attempt and req1 stalled behind it.
    log_q.delete();
    clear_start = 1'b1; clear_rgb = 9'o000;
    step();
    clear_start = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_x = 8'd5; bus.req1_y = 8'd6; bus.req1_rgb = 9'o777;
    done_cnt = 0; busy_cyc = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (busy) begin
        busy_cyc++;
        chk("clr_req1_stalled", bus.req1_ready, 0);
      end
      if (clear_done) begin
        done_cnt++;
        chk("clr_done_x", bus.wr_x, XMAX);
        chk("clr_done_y", bus.wr_y, YMAX);
      end
      got = bus.req1_ready;
      step();
      clear_start = (i == 3);
      if (got) break;
    end
    clear_start = 1'b0;
    bus.req1_valid = 1'b0;
    chk("clr_req1_accepted", got, 1);
    repeat (3) step();
    chk("clr_done_count", done_cnt, 1);
    chk("clr_busy_cycles", busy_cyc, 8);
    chk("clr_write_count", log_q.size(), TOTAL + 1);
    for (int n = 0; n < TOTAL + 1 && n < log_q.size(); n++) begin
      e = (n < TOTAL) ? {XW'(n % W), YW'(n / W), 9'o000} : {8'd5, 8'd6, 9'o777};
      chk("clr_write_seq", log_q[n], e);
    end
    do_reset(1'b0);

    // Randomized traffic, back-pressure and occasional clears.
    for (int i = 0; i < 600; i++) begin
      @(posedge CLK);
      #1;
      bus.wr_ready = ($urandom_range(0, 3) != 0);
      if (!bus.req0_valid || m_r0) begin
        bus.req0_valid = ($urandom_range(0, 9) < 6);
        bus.req0_x = XW'($urandom); bus.req0_y = YW'($urandom); bus.req0_rgb = 9'($urandom);
      end
      if (!bus.req1_valid || m_r1) begin
        bus.req1_valid = ($urandom_range(0, 9) < 6);
        bus.req1_x = XW'($urandom); bus.req1_y = YW'($urandom); bus.req1_rgb = 9'($urandom);
      end
      clear_start = ($urandom_range(0, 59) == 0);
      clear_rgb = 9'($urandom);
    end
    do_reset(1'b0);

    // Reset mid-sweep abandons the clear.
    clear_start = 1'b1; clear_rgb = 9'o555;
    step();
    clear_start = 1'b0;
    repeat (3) step();
    do_reset(1'b1);
    log_q.delete();
    repeat (12) step();
    chk("rst_sweep_no_writes", log_q.size(), 0);
    chk("rst_sweep_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
